// File: rtl/block_ram_stream_loader.sv
// Packs PACK narrow stream beats per RAM word and writes a wrap-around address range, pulsing done after the last write.
// Latency: last beat accepted at edge N -> final wr_en in cycle N+1, done in N+2; s_ready is high only in LOAD.
module block_ram_stream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int IN_WIDTH   = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [CW-1:0]         num_words,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [AW-1:0]         wr_addr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done
);

  localparam int PACK = DATA_WIDTH / IN_WIDTH;
  localparam int PW   = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_BEAT = PW'(PACK - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]         addr;
  logic [CW-1:0]         words_left;
  logic [PW-1:0]         pack_cnt;
  logic [DATA_WIDTH-1:0] pack_reg;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  beat_acc;
  logic                  word_cmp;
  logic                  last_word;
  logic                  addr_oob;

  assign s_ready   = (state == LOAD);
  assign beat_acc  = s_valid && s_ready;
  assign word_cmp  = beat_acc && (pack_cnt == LAST_BEAT);
  assign last_word = (words_left == CW'(1));
  // Out-of-range start addresses fall back to word 0; DEPTH need not be a power of two.
  assign addr_oob  = ({1'b0, start_addr} >= DEPTH_W);

  // Merge the current beat into its slice so a completing beat can be written without an extra cycle.
  always_comb begin
    word_nxt = pack_reg;
    word_nxt[int'(pack_cnt) * IN_WIDTH +: IN_WIDTH] = s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_words == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (word_cmp && last_word) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_data    <= '0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr       <= '0;
      words_left <= '0;
      pack_cnt   <= '0;
      pack_reg   <= '0;
    end else begin
      wr_en <= 1'b0;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);

      if (state == IDLE && start) begin
        addr       <= addr_oob ? '0 : start_addr;
        words_left <= num_words;
        pack_cnt   <= '0;
        pack_reg   <= '0;
      end

      if (beat_acc) begin
        pack_reg <= word_nxt;
        pack_cnt <= (pack_cnt == LAST_BEAT) ? '0 : pack_cnt + 1'b1;
      end

      // wr_data/wr_addr only move with a write, so they hold between words.
      if (word_cmp) begin
        wr_en      <= 1'b1;
        wr_data    <= word_nxt;
        wr_addr    <= addr;
        addr       <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        words_left <= words_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_block_ram_stream_loader.sv
// Bench for block_ram_stream_loader: 16/8/4 instance (a_*) for most cases, 8/8/3 instance (b_*) for the PACK=1 case.
module tb_block_ram_stream_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_start;
  logic [1:0]  a_start_addr;
  logic [2:0]  a_num_words;
  logic [7:0]  a_s_data;
  logic        a_s_valid;
  logic        a_s_ready;
  logic [15:0] a_wr_data;
  logic [1:0]  a_wr_addr;
  logic        a_wr_en;
  logic        a_busy;
  logic        a_done;

  logic        b_start;
  logic [1:0]  b_start_addr;
  logic [1:0]  b_num_words;
  logic [7:0]  b_s_data;
  logic        b_s_valid;
  logic        b_s_ready;
  logic [7:0]  b_wr_data;
  logic [1:0]  b_wr_addr;
  logic        b_wr_en;
  logic        b_busy;
  logic        b_done;

  block_ram_stream_loader #(.DATA_WIDTH(16), .DEPTH(4), .IN_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .start_addr(a_start_addr), .num_words(a_num_words),
    .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .wr_data(a_wr_data), .wr_addr(a_wr_addr), .wr_en(a_wr_en), .busy(a_busy), .done(a_done)
  );

  block_ram_stream_loader #(.DATA_WIDTH(8), .DEPTH(3), .IN_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .start_addr(b_start_addr), .num_words(b_num_words),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .wr_data(b_wr_data), .wr_addr(b_wr_addr), .wr_en(b_wr_en), .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // RAM models fed from the write pins.
  logic [15:0] ram_a [4];
  logic [7:0]  ram_b [3];
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int done_cnt_a = 0;

  always @(negedge clk) begin
    if (a_wr_en) begin
      ram_a[a_wr_addr] = a_wr_data;
      wr_cnt_a++;
      chk("A wr_en outside LOAD/FLUSH", {31'b0, a_busy && !a_done}, 32'd1);
    end
    if (b_wr_en) begin
      ram_b[b_wr_addr] = b_wr_data;
      wr_cnt_b++;
      chk("B wr_en outside LOAD/FLUSH", {31'b0, b_busy && !b_done}, 32'd1);
    end
    if (a_done) done_cnt_a++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_a(input logic [1:0] ad, input logic [2:0] nw);
    a_start = 1'b1;
    a_start_addr = ad;
    a_num_words = nw;
    step();
    a_start = 1'b0;
  endtask

  task automatic send_one_a(input logic [7:0] d);
    int t;
    t = 0;
    a_s_valid = 1'b1;
    a_s_data = d;
    while (!a_s_ready && t < 50) begin
      step();
      t++;
    end
    chk("A beat accepted", {31'b0, (t < 50)}, 32'd1);
    step();
    a_s_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    int t;
    t = 0;
    while (!a_done && t < 50) begin
      step();
      t++;
    end
    chk("A done seen", {31'b0, (t < 50)}, 32'd1);
  endtask

  typedef struct {
    logic        start;
    logic [1:0]  addr;
    logic [2:0]  nw;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tv [8];

  initial begin
    int wr0;
    int d0;
    logic [7:0] beats [8];

    // Each row: outputs expected now, then inputs driven for the next edge.
    tv[0] = '{1'b1, 2'd0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tv[1] = '{1'b0, 2'd0, 3'd0, 1'b1, 8'h11, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{1'b0, 2'd0, 3'd0, 1'b1, 8'h22, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0};
    tv[3] = '{1'b0, 2'd0, 3'd0, 1'b1, 8'h33, 1'b1, 1'b1, 2'd0, 16'h2211, 1'b1, 1'b0};
    tv[4] = '{1'b0, 2'd0, 3'd0, 1'b1, 8'h44, 1'b1, 1'b0, 2'd0, 16'h2211, 1'b1, 1'b0};
    tv[5] = '{1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 16'h4433, 1'b1, 1'b0};
    tv[6] = '{1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 16'h4433, 1'b1, 1'b1};
    tv[7] = '{1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 16'h4433, 1'b0, 1'b0};

    foreach (ram_a[i]) ram_a[i] = '0;
    foreach (ram_b[i]) ram_b[i] = '0;

    rst = 1'b1;
    a_start = 1'b0; a_start_addr = '0; a_num_words = '0; a_s_data = '0; a_s_valid = 1'b0;
    b_start = 1'b0; b_start_addr = '0; b_num_words = '0; b_s_data = '0; b_s_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    chk("B reset wr_en", {31'b0, b_wr_en}, 32'd0);
    chk("B reset busy", {31'b0, b_busy}, 32'd0);
    chk("B reset s_ready", {31'b0, b_s_ready}, 32'd0);

    // T1 basic, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("T1[%0d] s_ready", i), {31'b0, a_s_ready}, {31'b0, tv[i].rdy});
      chk($sformatf("T1[%0d] wr_en", i), {31'b0, a_wr_en}, {31'b0, tv[i].we});
      chk($sformatf("T1[%0d] wr_addr", i), {30'b0, a_wr_addr}, {30'b0, tv[i].wa});
      chk($sformatf("T1[%0d] wr_data", i), {16'b0, a_wr_data}, {16'b0, tv[i].wd});
      chk($sformatf("T1[%0d] busy", i), {31'b0, a_busy}, {31'b0, tv[i].busy});
      chk($sformatf("T1[%0d] done", i), {31'b0, a_done}, {31'b0, tv[i].done});
      a_start = tv[i].start;
      a_start_addr = tv[i].addr;
      a_num_words = tv[i].nw;
      a_s_valid = tv[i].vld;
      a_s_data = tv[i].dat;
      step();
    end
    chk("T1 ram0", {16'b0, ram_a[0]}, 32'h2211);
    chk("T1 ram1", {16'b0, ram_a[1]}, 32'h4433);
    chk("T1 writes", wr_cnt_a, 2);

    // T2 wrap from address 3 over all four words
    wr0 = wr_cnt_a;
    beats = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    start_a(2'd3, 3'd4);
    for (int i = 0; i < 8; i++) send_one_a(beats[i]);
    wait_done_a();
    step();
    chk("T2 done one cycle", {31'b0, a_done}, 32'd0);
    chk("T2 busy low", {31'b0, a_busy}, 32'd0);
    chk("T2 ram3", {16'b0, ram_a[3]}, 32'h0201);
    chk("T2 ram0", {16'b0, ram_a[0]}, 32'h0403);
    chk("T2 ram1", {16'b0, ram_a[1]}, 32'h0605);
    chk("T2 ram2", {16'b0, ram_a[2]}, 32'h0807);
    chk("T2 writes", wr_cnt_a - wr0, 4);

    // T3 stalled stream: valid 1,0,0 per beat
    wr0 = wr_cnt_a;
    d0 = done_cnt_a;
    beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    start_a(2'd0, 3'd2);
    for (int i = 0; i < 4; i++) begin
      send_one_a(beats[i]);
      chk($sformatf("T3 writes after beat %0d", i), wr_cnt_a - wr0, (i + 1) / 2);
      repeat (2) step();
    end
    chk("T3 done pulses", done_cnt_a - d0, 1);
    chk("T3 ram0", {16'b0, ram_a[0]}, 32'h2211);
    chk("T3 ram1", {16'b0, ram_a[1]}, 32'h4433);

    // T4 zero-length load, beats offered but never taken
    wr0 = wr_cnt_a;
    d0 = done_cnt_a;
    a_s_valid = 1'b1;
    a_s_data = 8'h99;
    start_a(2'd1, 3'd0);
    chk("T4 s_ready", {31'b0, a_s_ready}, 32'd0);
    chk("T4 done", {31'b0, a_done}, 32'd1);
    step();
    chk("T4 done low", {31'b0, a_done}, 32'd0);
    chk("T4 busy low", {31'b0, a_busy}, 32'd0);
    a_s_valid = 1'b0;
    chk("T4 writes", wr_cnt_a - wr0, 0);
    chk("T4 done pulses", done_cnt_a - d0, 1);

    // T4b start while busy is ignored
    wr0 = wr_cnt_a;
    start_a(2'd0, 3'd1);
    start_a(2'd2, 3'd3);
    send_one_a(8'hEF);
    send_one_a(8'hBE);
    wait_done_a();
    step();
    chk("T4b busy low", {31'b0, a_busy}, 32'd0);
    chk("T4b writes", wr_cnt_a - wr0, 1);
    chk("T4b ram0", {16'b0, ram_a[0]}, 32'hBEEF);
    chk("T4b ram2", {16'b0, ram_a[2]}, 32'h0807);

    // T5 reset after three beats
    wr0 = wr_cnt_a;
    d0 = done_cnt_a;
    start_a(2'd0, 3'd2);
    send_one_a(8'h11);
    send_one_a(8'h22);
    send_one_a(8'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("T5 busy after rst", {31'b0, a_busy}, 32'd0);
    chk("T5 wr_en after rst", {31'b0, a_wr_en}, 32'd0);
    chk("T5 s_ready after rst", {31'b0, a_s_ready}, 32'd0);
    repeat (5) step();
    chk("T5 no done", done_cnt_a - d0, 0);
    chk("T5 writes", wr_cnt_a - wr0, 1);
    chk("T5 ram0", {16'b0, ram_a[0]}, 32'h2211);
    chk("T5 ram1 untouched", {16'b0, ram_a[1]}, 32'h4433);
    wr0 = wr_cnt_a;
    start_a(2'd0, 3'd2);
    for (int i = 0; i < 4; i++) send_one_a(beats[i]);
    wait_done_a();
    chk("T5 rerun writes", wr_cnt_a - wr0, 2);
    chk("T5 rerun ram1", {16'b0, ram_a[1]}, 32'h4433);

    // T6 PACK=1, out-of-range start (3 is the only such value 2 bits can carry)
    b_start = 1'b1;
    b_start_addr = 2'd3;
    b_num_words = 2'd3;
    step();
    b_start = 1'b0;
    chk("T6 s_ready", {31'b0, b_s_ready}, 32'd1);
    b_s_valid = 1'b1;
    b_s_data = 8'hAA;
    step();
    chk("T6 w0 en", {31'b0, b_wr_en}, 32'd1);
    chk("T6 w0 addr", {30'b0, b_wr_addr}, 32'd0);
    chk("T6 w0 data", {24'b0, b_wr_data}, 32'hAA);
    b_s_data = 8'hBB;
    step();
    chk("T6 w1 en", {31'b0, b_wr_en}, 32'd1);
    chk("T6 w1 addr", {30'b0, b_wr_addr}, 32'd1);
    b_s_data = 8'hCC;
    step();
    chk("T6 w2 en", {31'b0, b_wr_en}, 32'd1);
    chk("T6 w2 addr", {30'b0, b_wr_addr}, 32'd2);
    chk("T6 flush s_ready", {31'b0, b_s_ready}, 32'd0);
    b_s_valid = 1'b0;
    step();
    chk("T6 done", {31'b0, b_done}, 32'd1);
    chk("T6 wr_en in DONE", {31'b0, b_wr_en}, 32'd0);
    step();
    chk("T6 busy low", {31'b0, b_busy}, 32'd0);
    chk("T6 ram0", {24'b0, ram_b[0]}, 32'hAA);
    chk("T6 ram1", {24'b0, ram_b[1]}, 32'hBB);
    chk("T6 ram2", {24'b0, ram_b[2]}, 32'hCC);
    chk("T6 writes", wr_cnt_b, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
